// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard control for the 5-stage pipeline.
// Each source operand has its own lane that produces the EX forwarding select
// and the load-use match. The top level combines the lanes, runs the RUN/BUBBLE
// stall FSM, and keeps a saturating count of bubble cycles.

module fwd_hazard_lane #(
    parameter int REG_AW   = 4,
    parameter int ZERO_REG = 1
) (
    input  logic              rst,
    input  logic [REG_AW-1:0] id_ex_src,
    input  logic [REG_AW-1:0] if_id_src,
    input  logic              if_id_src_vld,
    input  logic [REG_AW-1:0] id_ex_rd,
    input  logic [REG_AW-1:0] ex_mem_rd,
    input  logic              ex_mem_regwrite,
    input  logic [REG_AW-1:0] mem_wb_rd,
    input  logic              mem_wb_regwrite,
    output logic [1:0]        sel,
    output logic              lu_match
);

    // Register 0 never matches when it is the hardwired-zero register.
    function automatic logic reg_match(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
        return (a == b) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // Forward select for this source: EX/MEM beats MEM/WB; forced to regfile during reset.
    always_comb begin
        sel      = 2'b00;
        lu_match = if_id_src_vld && reg_match(id_ex_rd, if_id_src);
        if (!rst) begin
            if (ex_mem_regwrite && reg_match(ex_mem_rd, id_ex_src))
                sel = 2'b10;
            else if (mem_wb_regwrite && reg_match(mem_wb_rd, id_ex_src))
                sel = 2'b01;
        end
    end

endmodule

module fwd_hazard_unit #(
    parameter int REG_AW   = 4,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC*REG_AW-1:0] if_id_src,
    input  logic [NUM_SRC-1:0]        if_id_src_vld,
    input  logic [NUM_SRC*REG_AW-1:0] id_ex_src,
    input  logic [REG_AW-1:0]         id_ex_rd,
    input  logic                      id_ex_regwrite,
    input  logic                      id_ex_memread,
    input  logic [REG_AW-1:0]         ex_mem_rd,
    input  logic                      ex_mem_regwrite,
    input  logic                      ex_mem_memwrite,
    input  logic [REG_AW-1:0]         ex_mem_rt,
    input  logic [REG_AW-1:0]         mem_wb_rd,
    input  logic                      mem_wb_regwrite,
    input  logic                      mem_stall_in,
    output logic [2*NUM_SRC-1:0]      fwd_sel,
    output logic                      fwd_mm,
    output logic                      pc_write_en,
    output logic                      if_id_write_en,
    output logic                      id_ex_flush,
    output logic [CNT_W-1:0]          stall_cycles
);

    localparam int CW = $clog2(LOAD_LAT + 1);

    typedef enum logic {RUN, BUBBLE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          stall;
    logic          lu_hit;
    logic [NUM_SRC-1:0] lu_src_hit;

    function automatic logic reg_match(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
        return (a == b) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_lane
        fwd_hazard_lane #(
            .REG_AW   (REG_AW),
            .ZERO_REG (ZERO_REG)
        ) u_lane (
            .rst             (rst),
            .id_ex_src       (id_ex_src[g*REG_AW +: REG_AW]),
            .if_id_src       (if_id_src[g*REG_AW +: REG_AW]),
            .if_id_src_vld   (if_id_src_vld[g]),
            .id_ex_rd        (id_ex_rd),
            .ex_mem_rd       (ex_mem_rd),
            .ex_mem_regwrite (ex_mem_regwrite),
            .mem_wb_rd       (mem_wb_rd),
            .mem_wb_regwrite (mem_wb_regwrite),
            .sel             (fwd_sel[2*g +: 2]),
            .lu_match        (lu_src_hit[g])
        );
    end

    assign lu_hit = id_ex_memread && id_ex_regwrite && (|lu_src_hit);

    // Store-data forwarding from WB into MEM, independent of the EX selects.
    assign fwd_mm = !rst && ex_mem_memwrite && mem_wb_regwrite && reg_match(mem_wb_rd, ex_mem_rt);

    // State, bubble counter and saturating stall counter; everything holds while frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            cnt          <= '0;
            stall_cycles <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (stall && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

    // Next-state logic: a load-use hit in RUN opens LOAD_LAT bubble cycles in total.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        if (!mem_stall_in) begin
            case (state)
                RUN: begin
                    if (lu_hit) begin
                        stall     = 1'b1;
                        cnt_nxt   = CW'(LOAD_LAT - 1);
                        state_nxt = (LOAD_LAT > 1) ? BUBBLE : RUN;
                    end
                end
                BUBBLE: begin
                    stall   = 1'b1;
                    cnt_nxt = cnt - CW'(1);
                    if (cnt_nxt == '0)
                        state_nxt = RUN;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    // Pipeline control: reset forces a bubble, a D-cache freeze holds everything.
    always_comb begin
        if (rst) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_flush    = 1'b1;
        end else if (mem_stall_in) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_flush    = 1'b0;
        end else begin
            pc_write_en    = !stall;
            if_id_write_en = !stall;
            id_ex_flush    = stall;
        end
    end

endmodule
